datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 92 +++++++++
 tb/tb_datapath.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   Shift-add multiplier datapath: a 64-bit product register whose lower half
//   is loaded with the multiplier on reset. Add and shift steps are issued by
//   an external controller. A 6-bit iteration counter tells the controller
//   when 32 iterations are done.
//
//   Optional feature: define DATAPATH_CARRY_EN to keep the adder carry-out.
//   With the macro, the carry goes into product[63] on the next shift, so
//   products are exact for all operands. Without it, the adder truncates to
//   32 bits and zero is shifted into bit 63.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   async active-high reset; loads {0, multiplier}
//   multiplicand in   32  added to product[63:32] on add (read live)
//   multiplier   in   32  sampled into product[31:0] only while rst=1
//   shr          in   1   shift product right by one this cycle
//   add          in   1   add multiplicand into upper half this cycle
//   incr         in   1   increment iteration counter (mod 64)
//   write        out  1   product[0]; tells the controller to add
//   less32       out  1   counter < 32
//   result       out  64  product register
// -----------------------------------------------------------------------------
module datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic        shr,
    input  logic        add,
    input  logic        incr,
    output logic        write,
    output logic        less32,
    output logic [63:0] result
);

    logic [63:0] product;
    logic [5:0]  counter;
    logic [31:0] sum;
    logic        cout;     // adder carry-out, 0 when the carry is disabled
    logic        shift_in; // bit entering product[63] on a shift-only cycle

`ifdef DATAPATH_CARRY_EN
    logic carry;

    assign {cout, sum} = {1'b0, product[63:32]} + {1'b0, multiplicand};
    assign shift_in    = carry;

    // The carry survives only until the next shift. A combined add+shr
    // routes the carry-out straight into bit 63, so the register clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            carry <= 1'b0;
        else if (shr)
            carry <= 1'b0;
        else if (add)
            carry <= cout;
    end
`else
    assign sum      = product[63:32] + multiplicand;
    assign cout     = 1'b0;
    assign shift_in = 1'b0;
`endif

    // The reset value comes from the multiplier port. While rst is held,
    // the register tracks that port asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= {32'b0, multiplier};
        end else begin
            unique case ({add, shr})
                2'b10:   product[63:32] <= sum;
                2'b01:   product        <= {shift_in, product[63:1]};
                2'b11:   product        <= {cout, sum, product[31:1]};
                default: product        <= product;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            counter <= 6'd0;
        else if (incr)
            counter <= counter + 6'd1;
    end

    assign result = product;
    assign write  = product[0];
    assign less32 = ~counter[5];

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//   Self-checking bench for datapath. A behavioural model keeps
//   {carry, product} as a single 65-bit value. An add is a 65-bit addition
//   of multiplicand<<32, and a shift is a plain >>1 of that value. A negedge
//   compare process checks the DUT against the model on every cycle.
//   Literal expectations pin the model to hand-computed values.
//   Define DATAPATH_CARRY_EN for both the bench and the RTL to test the
//   carry build.
// -----------------------------------------------------------------------------
module tb_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        shr = 1'b0;
    logic        add = 1'b0;
    logic        incr = 1'b0;
    logic        write;
    logic        less32;
    logic [63:0] result;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    datapath dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .shr          (shr),
        .add          (add),
        .incr         (incr),
        .write        (write),
        .less32       (less32),
        .result       (result)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [64:0] m_v;   // {carry, product}
    logic [5:0]  m_cnt;

    function automatic logic [64:0] nxt(input logic [64:0] v, input logic a,
                                        input logic s, input logic [31:0] mc);
        logic [64:0] t;
        t = v;
        if (a) begin
            t = {1'b0, v[63:0]} + {1'b0, mc, 32'b0};
`ifndef DATAPATH_CARRY_EN
            t[64] = 1'b0;
`endif
        end
        if (s) t = t >> 1;
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v   <= {33'b0, multiplier};
            m_cnt <= 6'd0;
        end else begin
            m_v <= nxt(m_v, add, shr, multiplicand);
            if (incr) m_cnt <= m_cnt + 6'd1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_result", result, m_v[63:0]);
            chk("cmp_write", {63'b0, write}, {63'b0, m_v[0]});
            chk("cmp_less32", {63'b0, less32}, {63'b0, (m_cnt < 6'd32)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic a, input logic s, input logic i);
        add = a; shr = s; incr = i;
        @(posedge clk);
        #1;
        add = 1'b0; shr = 1'b0; incr = 1'b0;
    endtask

    // Pulse reset between clock edges. The caller is at posedge+1.
    task automatic do_reset(input logic [31:0] mul, input logic [31:0] mc);
        multiplier = mul;
        multiplicand = mc;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic run_mul(input string name, input logic [31:0] mc,
                           input logic [31:0] mul, input logic [63:0] exp,
                           input logic combined);
        do_reset(mul, mc);
        for (int k = 0; k < 32; k++) begin
            if (combined) begin
                step(write, 1'b1, 1'b1);
            end else begin
                if (write) step(1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b1);
            end
        end
        chk(name, result, exp);
        chk({name, "_less32"}, {63'b0, less32}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        // Reset scenario
        multiplier = 32'd14; multiplicand = 32'd11;
        rst = 1'b1;
        #1;
        chk("rst_result", result, 64'h0000_0000_0000_000E);
        chk("rst_write", {63'b0, write}, 64'd0);
        chk("rst_less32", {63'b0, less32}, 64'd1);
        chk("rst_counter", {58'b0, dut.counter}, 64'd0);
        // Controls are ignored while reset is held across an edge.
        add = 1'b1; shr = 1'b1; incr = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_result", result, 64'h0000_0000_0000_000E);
        chk("rst_hold_counter", {58'b0, dut.counter}, 64'd0);
        add = 1'b0; shr = 1'b0; incr = 1'b0;
        #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // Step sequence
        step(1'b0, 1'b1, 1'b1);
        chk("s1_result", result, 64'h7);
        chk("s1_write", {63'b0, write}, 64'd1);
        chk("s1_counter", {58'b0, dut.counter}, 64'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("s2_result", result, 64'h0000_000B_0000_0007);
        chk("s2_counter", {58'b0, dut.counter}, 64'd2);
        step(1'b0, 1'b1, 1'b0);
        chk("s3_result", result, 64'h0000_0005_8000_0003);
        chk("s3_counter", {58'b0, dut.counter}, 64'd2);

        // Mid-operation async reset, asserted between edges
        #2;
        multiplier = 32'h0000_0123;
        rst = 1'b1;
        #1;
        chk("mid_rst_result", result, 64'h0000_0000_0000_0123);
        chk("mid_rst_counter", {58'b0, dut.counter}, 64'd0);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("mid_rst_after", result, 64'h0000_0000_0000_0091);

        // Full multiplies
        run_mul("mul_11x14", 32'd11, 32'd14, 64'd154, 1'b1);
        run_mul("mul_11x14_sep", 32'd11, 32'd14, 64'd154, 1'b0);
`ifdef DATAPATH_CARRY_EN
        run_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_mul("mul_max_comb", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        for (int r = 0; r < 4; r++) begin
            a = $urandom; b = $urandom;
            run_mul("mul_rand32", a, b, 64'(a) * 64'(b), r[0]);
        end
`endif
        for (int r = 0; r < 4; r++) begin
            a = $urandom_range(0, 32'hFFFF); b = $urandom_range(0, 32'hFFFF);
            run_mul("mul_rand16", a, b, 64'(a) * 64'(b), r[0]);
        end

        // Counter boundary
        do_reset(32'h5, 32'h3);
        repeat (31) step(1'b0, 1'b0, 1'b1);
        chk("cnt31_less32", {63'b0, less32}, 64'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("cnt32_less32", {63'b0, less32}, 64'd0);
        repeat (32) step(1'b0, 1'b0, 1'b1);
        chk("cnt64_counter", {58'b0, dut.counter}, 64'd0);
        chk("cnt64_less32", {63'b0, less32}, 64'd1);
        chk("cnt64_hold", result, 64'h5);

        // Random control and operand traffic with occasional resets.
        // The multiplier also changes outside reset and must be ignored.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset($urandom, $urandom);
            end else begin
                multiplicand = $urandom;
                if ($urandom_range(0, 3) == 0) multiplier = $urandom;
                step(1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
